// File: rtl/sys_defs.sv
// Shared system definitions: bus command/size encodings, address width and
// memory tag width used by the memory-side blocks.
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;
   localparam int XLEN          = `XLEN;
   localparam int MEM_TAG_WIDTH = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic [1:0] {
      BYTE   = 2'h0,
      HALF   = 2'h1,
      WORD   = 2'h2,
      DOUBLE = 2'h3
   } MEM_SIZE;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
      return c;
   endfunction
endpackage

// File: rtl/mem_tag_table.sv
// Tracks which requester owns each in-flight memory load tag (1..15),
// flags protocol errors and keeps a registered count of live entries.
module mem_tag_table
   import sys_defs::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     alloc_en,
   input  logic [MEM_TAG_WIDTH-1:0] alloc_tag,
   input  logic                     alloc_owner,
   input  logic [MEM_TAG_WIDTH-1:0] ret_tag,
   output logic                     ret_hit,
   output logic                     ret_owner,
   output logic [4:0]               outstanding_cnt,
   output logic                     tag_err
);
   // Bit 0 is never set: tag 0 means "no tag" on both ports.
   logic [15:0] valid, owner;
   logic [15:0] valid_next, owner_next;
   logic        err_next;

   always_comb begin
      valid_next = valid;
      owner_next = owner;
      err_next   = tag_err;
      ret_hit    = (ret_tag != '0) && valid[ret_tag];
      ret_owner  = owner[ret_tag];
      if ((ret_tag != '0) && !valid[ret_tag]) err_next = 1'b1;
      if (ret_hit) valid_next[ret_tag] = 1'b0;
      // Return is applied first, so a same-cycle return/reuse of one tag is legal.
      if (alloc_en && (alloc_tag != '0)) begin
         if (valid_next[alloc_tag]) err_next = 1'b1;
         valid_next[alloc_tag] = 1'b1;
         owner_next[alloc_tag] = alloc_owner;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid           <= '0;
         owner           <= '0;
         tag_err         <= 1'b0;
         outstanding_cnt <= '0;
      end else begin
         valid           <= valid_next;
         owner           <= owner_next;
         tag_err         <= err_next;
         outstanding_cnt <= popcount16(valid_next);
      end
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single memory bus between instruction and data memory
// requesters, with Imem starvation protection and tag-based return routing.
module mem_bus_arbiter
   import sys_defs::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  BUS_COMMAND               Imem2mem_command,
   input  logic [`XLEN-1:0]         Imem2mem_addr,
   input  MEM_SIZE                  Imem2mem_size,
   input  BUS_COMMAND               Dmem2mem_command,
   input  logic [`XLEN-1:0]         Dmem2mem_addr,
   input  logic [63:0]              Dmem2mem_data,
   input  MEM_SIZE                  Dmem2mem_size,
   input  logic [3:0]               mem2proc_response,
   input  logic [63:0]              mem2proc_data,
   input  logic [3:0]               mem2proc_tag,
   output BUS_COMMAND               proc2mem_command,
   output logic [`XLEN-1:0]         proc2mem_addr,
   output logic [63:0]              proc2mem_data,
   output MEM_SIZE                  proc2mem_size,
   output logic [3:0]               mem2Imem_response,
   output logic [3:0]               mem2Imem_tag,
   output logic [63:0]              mem2Imem_data,
   output logic [3:0]               mem2Dmem_response,
   output logic [3:0]               mem2Dmem_tag,
   output logic [63:0]              mem2Dmem_data,
   output logic                     grant_imem,
   output logic [4:0]               outstanding_cnt,
   output logic                     tag_err
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic          imem_req, dmem_req, grant_dmem;
   logic [SW-1:0] starve_cnt, starve_next;
   logic          alloc_en, ret_hit, ret_owner;

   assign imem_req   = (Imem2mem_command == BUS_LOAD);
   assign dmem_req   = (Dmem2mem_command != BUS_NONE);
   assign grant_imem = imem_req && (!dmem_req || (starve_cnt == LIMIT));
   assign grant_dmem = dmem_req && !grant_imem;

   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      proc2mem_size    = BYTE;
      if (grant_imem) begin
         proc2mem_command = Imem2mem_command;
         proc2mem_addr    = Imem2mem_addr;
         proc2mem_size    = Imem2mem_size;
      end else if (grant_dmem) begin
         proc2mem_command = Dmem2mem_command;
         proc2mem_addr    = Dmem2mem_addr;
         proc2mem_data    = Dmem2mem_data;
         proc2mem_size    = Dmem2mem_size;
      end
   end

   assign mem2Imem_response = grant_imem ? mem2proc_response : '0;
   assign mem2Dmem_response = grant_dmem ? mem2proc_response : '0;
   assign mem2Imem_data     = mem2proc_data;
   assign mem2Dmem_data     = mem2proc_data;
   assign mem2Imem_tag      = (ret_hit && !ret_owner) ? mem2proc_tag : '0;
   assign mem2Dmem_tag      = (ret_hit &&  ret_owner) ? mem2proc_tag : '0;

   // A denial is either losing arbitration or the memory rejecting the load.
   always_comb begin
      starve_next = '0;
      if (imem_req && !(grant_imem && (mem2proc_response != '0)))
         starve_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + SW'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) starve_cnt <= '0;
      else       starve_cnt <= starve_next;
   end

   assign alloc_en = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);

   mem_tag_table u_tag_table (
      .clock           (clock),
      .reset           (reset),
      .alloc_en        (alloc_en),
      .alloc_tag       (mem2proc_response),
      .alloc_owner     (grant_dmem),
      .ret_tag         (mem2proc_tag),
      .ret_hit         (ret_hit),
      .ret_owner       (ret_owner),
      .outstanding_cnt (outstanding_cnt),
      .tag_err         (tag_err)
   );
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-vector bench for mem_bus_arbiter with a rule-level model of
// arbitration, starvation and tag ownership checked every cycle.
module tb_mem_bus_arbiter;
   import sys_defs::*;

   localparam int LIMIT = 4;

   logic               clock, reset;
   BUS_COMMAND         icmd, dcmd, p_cmd;
   logic [XLEN-1:0]    iaddr, daddr, p_addr;
   MEM_SIZE            isize, dsize, p_size;
   logic [63:0]        ddata, rdata, p_data, i_data, d_data;
   logic [3:0]         resp, rtag, i_resp, i_tag, d_resp, d_tag;
   logic               grant_imem, tag_err;
   logic [4:0]         outstanding_cnt;

   int nvec = 0;
   int nmis = 0;

   mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .Imem2mem_command(icmd), .Imem2mem_addr(iaddr), .Imem2mem_size(isize),
      .Dmem2mem_command(dcmd), .Dmem2mem_addr(daddr), .Dmem2mem_data(ddata),
      .Dmem2mem_size(dsize),
      .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(rtag),
      .proc2mem_command(p_cmd), .proc2mem_addr(p_addr), .proc2mem_data(p_data),
      .proc2mem_size(p_size),
      .mem2Imem_response(i_resp), .mem2Imem_tag(i_tag), .mem2Imem_data(i_data),
      .mem2Dmem_response(d_resp), .mem2Dmem_tag(d_tag), .mem2Dmem_data(d_data),
      .grant_imem(grant_imem), .outstanding_cnt(outstanding_cnt), .tag_err(tag_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit mvalid [0:15];
   bit mowner [0:15];
   int mstarve = 0;
   bit merr = 0;

   always @(posedge reset) begin
      for (int i = 0; i < 16; i++) begin mvalid[i] = 0; mowner[i] = 0; end
      mstarve = 0;
      merr = 0;
   end

   always @(negedge clock) begin
      if (!reset) begin
         bit ireq, dreq, gi, gd, hit;
         int cnt, t, a;
         ireq = (icmd == BUS_LOAD);
         dreq = (dcmd != BUS_NONE);
         gi   = ireq && (!dreq || mstarve == LIMIT);
         gd   = dreq && !gi;
         t    = int'(rtag);
         a    = int'(resp);
         hit  = (t != 0) && mvalid[t];
         cnt  = 0;
         for (int i = 1; i < 16; i++) cnt += mvalid[i];

         chk("grant_imem", grant_imem, gi);
         chk("proc2mem_command", p_cmd, gi ? icmd : gd ? dcmd : BUS_NONE);
         chk("proc2mem_addr", p_addr, gi ? iaddr : gd ? daddr : '0);
         chk("proc2mem_data", p_data, gd ? ddata : 64'd0);
         chk("proc2mem_size", p_size, gi ? isize : gd ? dsize : BYTE);
         chk("mem2Imem_response", i_resp, gi ? resp : 4'd0);
         chk("mem2Dmem_response", d_resp, gd ? resp : 4'd0);
         chk("mem2Imem_tag", i_tag, (hit && !mowner[t]) ? rtag : 4'd0);
         chk("mem2Dmem_tag", d_tag, (hit && mowner[t]) ? rtag : 4'd0);
         chk("mem2Imem_data", i_data, rdata);
         chk("mem2Dmem_data", d_data, rdata);
         chk("outstanding_cnt", outstanding_cnt, cnt);
         chk("tag_err", tag_err, merr);

         if (t != 0 && !mvalid[t]) merr = 1;
         if (hit) mvalid[t] = 0;
         if ((gi || (gd && dcmd == BUS_LOAD)) && a != 0) begin
            if (mvalid[a]) merr = 1;
            mvalid[a] = 1;
            mowner[a] = gd;
         end
         if (ireq && !(gi && a != 0)) mstarve = (mstarve < LIMIT) ? mstarve + 1 : LIMIT;
         else                         mstarve = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input BUS_COMMAND ic, input logic [XLEN-1:0] ia,
                      input BUS_COMMAND dc, input logic [XLEN-1:0] da,
                      input logic [3:0] r, input logic [3:0] rt);
      @(posedge clock);
      #1;
      icmd  = ic;  iaddr = ia;  isize = WORD;
      dcmd  = dc;  daddr = da;  dsize = DOUBLE;
      ddata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      resp  = r;   rtag  = rt;
      @(negedge clock);
   endtask

   task automatic idle(input logic [3:0] rt);
      cyc(BUS_NONE, '0, BUS_NONE, '0, 4'd0, rt);
   endtask

   task automatic pulse_reset();
      @(posedge clock);
      #1 reset = 1'b1;
      icmd = BUS_NONE; dcmd = BUS_NONE; resp = '0; rtag = '0;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      icmd = BUS_NONE; iaddr = '0; isize = BYTE;
      dcmd = BUS_NONE; daddr = '0; dsize = BYTE; ddata = '0;
      resp = '0; rdata = '0; rtag = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("reset outstanding_cnt", outstanding_cnt, 5'd0);
      chk("reset tag_err", tag_err, 1'b0);
      chk("reset grant_imem", grant_imem, 1'b0);
      chk("reset proc2mem_command", p_cmd, BUS_NONE);

      // Both load, Dmem wins with tag 3.
      cyc(BUS_LOAD, 'h100, BUS_LOAD, 'h200, 4'd3, 4'd0);
      chk("s1 Dmem_response", d_resp, 4'd3);
      chk("s1 Imem_response", i_resp, 4'd0);
      chk("s1 grant_imem", grant_imem, 1'b0);
      chk("s1 proc2mem_addr", p_addr, 'h200);
      idle(4'd0);
      chk("s1 outstanding", outstanding_cnt, 5'd1);

      // Imem starved by four Dmem loads, forced through on the fifth cycle.
      for (int k = 0; k < 4; k++) begin
         cyc(BUS_LOAD, 'h300 + k, BUS_LOAD, 'h400 + k, 4'(8 + k), 4'd0);
         chk("s2 grant_imem low", grant_imem, 1'b0);
      end
      cyc(BUS_LOAD, 'h380, BUS_LOAD, 'h480, 4'd5, 4'd0);
      chk("s2 grant_imem forced", grant_imem, 1'b1);
      chk("s2 proc2mem_addr", p_addr, 'h380);
      chk("s2 proc2mem_data", p_data, 64'd0);
      chk("s2 Imem_response", i_resp, 4'd5);
      chk("s2 Dmem_response", d_resp, 4'd0);
      cyc(BUS_LOAD, 'h390, BUS_LOAD, 'h490, 4'd12, 4'd0);
      chk("s2 starve cleared", grant_imem, 1'b0);
      idle(4'd0);
      chk("s2 outstanding", outstanding_cnt, 5'd7);

      // Imem tag 5 returns.
      idle(4'd5);
      chk("s3 Imem_tag", i_tag, 4'd5);
      chk("s3 Dmem_tag", d_tag, 4'd0);
      idle(4'd0);
      chk("s3 outstanding", outstanding_cnt, 5'd6);

      // Tag 2 returns to Imem while Dmem reallocates it.
      cyc(BUS_LOAD, 'h500, BUS_NONE, '0, 4'd2, 4'd0);
      idle(4'd0);
      chk("s4 outstanding alloc", outstanding_cnt, 5'd7);
      cyc(BUS_NONE, '0, BUS_LOAD, 'h600, 4'd2, 4'd2);
      chk("s4 Imem_tag", i_tag, 4'd2);
      chk("s4 Dmem_tag", d_tag, 4'd0);
      idle(4'd0);
      chk("s4 outstanding same", outstanding_cnt, 5'd7);
      chk("s4 tag_err", tag_err, 1'b0);
      idle(4'd2);
      chk("s4 new owner Dmem_tag", d_tag, 4'd2);
      chk("s4 new owner Imem_tag", i_tag, 4'd0);

      // Store tag 7 never allocates; its return is an error.
      cyc(BUS_NONE, '0, BUS_STORE, 'h700, 4'd7, 4'd0);
      chk("s5 store response", d_resp, 4'd7);
      idle(4'd0);
      chk("s5 outstanding", outstanding_cnt, 5'd6);
      idle(4'd7);
      chk("s5 Imem_tag", i_tag, 4'd0);
      chk("s5 Dmem_tag", d_tag, 4'd0);
      idle(4'd0);
      chk("s5 tag_err", tag_err, 1'b1);

      // Fill all 15 tags, then overwrite one.
      pulse_reset();
      for (int t = 1; t < 16; t++) cyc(BUS_NONE, '0, BUS_LOAD, 'h800 + t, 4'(t), 4'd0);
      idle(4'd0);
      chk("s6 full", outstanding_cnt, 5'd15);
      chk("s6 tag_err clean", tag_err, 1'b0);
      cyc(BUS_NONE, '0, BUS_LOAD, 'h900, 4'd9, 4'd0);
      idle(4'd0);
      chk("s6 no overflow", outstanding_cnt, 5'd15);
      chk("s6 overwrite tag_err", tag_err, 1'b1);

      // Rejected Imem loads also count toward starvation.
      pulse_reset();
      repeat (4) cyc(BUS_LOAD, 'hA00, BUS_NONE, '0, 4'd0, 4'd0);
      cyc(BUS_LOAD, 'hA10, BUS_LOAD, 'hB10, 4'd0, 4'd0);
      chk("s7 rejected starve grant", grant_imem, 1'b1);

      // Asynchronous reset with three loads outstanding.
      pulse_reset();
      cyc(BUS_LOAD, 'hC00, BUS_NONE, '0, 4'd1, 4'd0);
      cyc(BUS_NONE, '0, BUS_LOAD, 'hC10, 4'd4, 4'd0);
      cyc(BUS_NONE, '0, BUS_LOAD, 'hC20, 4'd6, 4'd0);
      idle(4'd0);
      chk("s8 outstanding before", outstanding_cnt, 5'd3);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("s8 async outstanding", outstanding_cnt, 5'd0);
      chk("s8 async tag_err", tag_err, 1'b0);
      @(posedge clock);
      #1 reset = 1'b0;
      idle(4'd4);
      chk("s8 dropped Imem_tag", i_tag, 4'd0);
      chk("s8 dropped Dmem_tag", d_tag, 4'd0);
      idle(4'd0);
      chk("s8 tag_err", tag_err, 1'b1);

      idle(4'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive cycles a pending Imem request may be denied before it is forced through.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 Imem request inputs: Imem2mem_command (BUS_COMMAND, LOAD or NONE only), Imem2mem_addr (`XLEN bits), Imem2mem_size (MEM_SIZE).
REQ-005 Dmem request inputs: Dmem2mem_command (BUS_COMMAND), Dmem2mem_addr (`XLEN bits), Dmem2mem_data (64 bits), Dmem2mem_size (MEM_SIZE).
REQ-006 Memory return inputs: mem2proc_response (4 bits, accepted-request tag, 0 = rejected), mem2proc_data (64 bits), mem2proc_tag (4 bits, returning-load tag, 0 = none).
REQ-007 Memory request outputs: proc2mem_command (BUS_COMMAND), proc2mem_addr (`XLEN bits), proc2mem_data (64 bits), proc2mem_size (MEM_SIZE).
REQ-008 Imem return outputs: mem2Imem_response (4 bits), mem2Imem_tag (4 bits), mem2Imem_data (64 bits).
REQ-009 Dmem return outputs: mem2Dmem_response (4 bits), mem2Dmem_tag (4 bits), mem2Dmem_data (64 bits).
REQ-010 Status outputs: grant_imem (1 bit, Imem owns the bus this cycle), outstanding_cnt (5 bits, in-flight loads, 0..15), tag_err (1 bit, sticky).

Function
REQ-011 Requests: Dmem requests when Dmem2mem_command != BUS_NONE; Imem requests when Imem2mem_command == BUS_LOAD.
REQ-012 Grant is combinational: Imem wins if it requests and either Dmem is idle or starve_cnt == STARVE_LIMIT; otherwise Dmem wins if it requests; otherwise neither.
REQ-013 The winner's command, addr, size and data are driven to proc2mem_*. Imem data drives 0. No winner: BUS_NONE with addr, data and size all 0.
REQ-014 mem2proc_response goes to the winner's *_response; the loser's *_response is 0 in the same cycle (zero latency).
REQ-015 starve_cnt counter: increments, saturating at STARVE_LIMIT, when Imem requests but is not accepted (lost arbitration, or response == 0). It clears to 0 when Imem is accepted or Imem is idle.
REQ-016 Tag table: 15 entries (tags 1..15), each with valid + owner (0 = Imem, 1 = Dmem).
REQ-017 Allocation: a BUS_LOAD accepted with response t != 0 sets valid[t] = 1 and owner[t] = winner at the next edge.
REQ-018 Stores never allocate an entry.
REQ-019 Return: mem2proc_tag t != 0 with valid[t] = 1 drives t on the owner's *_tag and clears valid[t]; the other side's *_tag is 0.
REQ-020 mem2proc_data is broadcast to both *_data outputs unconditionally.
REQ-021 Same-cycle return of tag t and allocation of tag t: the return is routed using the old owner, then the allocation wins, so the entry ends valid with the new owner.
REQ-022 Return of a tag whose entry is invalid: dropped (both *_tag = 0) and tag_err set.
REQ-023 Allocation onto an already-valid tag: overwrites the entry and sets tag_err.
REQ-024 tag_err clears only on reset.
REQ-025 outstanding_cnt equals the population count of valid[], registered; it reaches 15 at full with no overflow.
REQ-026 grant_imem = 1 exactly in cycles where Imem is the winner per REQ-012.

Reset
REQ-027 On reset: all valid bits 0, all owners 0, starve_cnt 0, outstanding_cnt 0, tag_err 0.
REQ-028 Combinational outputs follow REQ-012..REQ-020 from the reset state; in-flight returns arriving during or after reset are dropped as invalid and flag tag_err once reset is released.

Structure
REQ-029 BUS_COMMAND, MEM_SIZE, `XLEN and a new MEM_TAG_WIDTH (4) constant reside in the shared sys_defs package.
REQ-030 The arbiter SHALL contain one sub-module, mem_tag_table (owner/valid array, allocate/return ports, popcount); grant logic and starve_cnt stay in the top.

Verification
REQ-031 Both request LOAD, response = 3: Dmem wins, mem2Dmem_response = 3, mem2Imem_response = 0, starve_cnt goes 0->1.
REQ-032 Dmem issues back-to-back loads for 4 cycles while Imem requests continuously (STARVE_LIMIT = 4): Imem is granted on the 5th cycle, grant_imem = 1, starve_cnt returns to 0 after acceptance.
REQ-033 Imem load accepted with tag 5, later mem2proc_tag = 5: mem2Imem_tag = 5, mem2Dmem_tag = 0, outstanding_cnt goes 1->0.
REQ-034 Dmem store accepted with tag 7, then mem2proc_tag = 7: no routing to either side, tag_err = 1.
REQ-035 Tag 2 owned by Imem returns in the same cycle Dmem load allocates tag 2: mem2Imem_tag = 2, entry 2 ends valid with owner Dmem, outstanding_cnt unchanged.
REQ-036 Assert reset asynchronously mid-stream with 3 loads outstanding: outstanding_cnt reads 0 immediately; a subsequent return of one of those tags is dropped and sets tag_err.
